pal_stream_checker: RTL and testbench

- Clocked, parametrised successor to the systolic palindrome cell chain.
- Accepts a stream of WIDTH-bit symbols over a valid/ready handshake. The string ends on the beat carrying in_last.
- Buffers the string, then compares mirrored symbol pairs LANES per cycle.
- Reports palindrome / not-palindrome, string length, and an overflow flag on a result handshake.
- Sits between a symbol source and any result consumer in the string-processing datapath.

---
 rtl/pal_pkg.sv | 16 +
 rtl/pal_pair_cmp.sv | 33 +++
 rtl/pal_stream_checker.sv | 152 +++++++++++++++
 tb/tb_pal_stream_checker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pal_pkg.sv
// Shared types and helpers for the palindrome stream checker.
// Holds the FSM state encoding and the length/index width helper.
package pal_pkg;

    typedef enum logic [1:0] {
        LOAD,
        CHECK,
        RESULT
    } state_t;

    // Width needed to hold a length in 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pal_pair_cmp.sv
// Compares up to LANES mirrored symbol pairs (lo+k vs hi-k) in one cycle.
// Ports: lo/hi window bounds, per-lane read data; mismatch, last_group out.
module pal_pair_cmp
    import pal_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LANES = 1,
    parameter int LW    = 5
) (
    input  logic [LW-1:0]    lo,
    input  logic [LW-1:0]    hi,
    input  logic [WIDTH-1:0] lo_data [LANES],
    input  logic [WIDTH-1:0] hi_data [LANES],
    output logic             mismatch,
    output logic             last_group
);

    always_comb begin
        mismatch = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            // lo+k < hi-k, rearranged so nothing can go negative
            if ((int'(lo) + 2 * k) < int'(hi)) begin
                if (lo_data[k] != hi_data[k]) begin
                    mismatch = 1'b1;
                end
            end
        end
    end

    // After stepping by LANES no pair with lo' < hi' would remain.
    assign last_group = (int'(lo) + 2 * LANES) >= int'(hi);

endmodule

// File: rtl/pal_stream_checker.sv
// Buffers a symbol stream and reports whether it is a palindrome.
// Ports: in_* symbol handshake (last ends string), out_* result handshake.
module pal_stream_checker
    import pal_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_LEN = 16,
    parameter int LANES   = 1,
    localparam int LW     = len_w(MAX_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_pal,
    output logic [LW-1:0]    out_len,
    output logic             out_overflow
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t             state;
    logic [LW-1:0]      cnt;
    logic [LW-1:0]      lo;
    logic [LW-1:0]      hi;
    logic               ovf;
    logic               mism;
    logic [WIDTH-1:0]   mem [MAX_LEN];
    logic [WIDTH-1:0]   lo_data [LANES];
    logic [WIDTH-1:0]   hi_data [LANES];
    logic               mismatch;
    logic               last_group;
    logic               accept;
    logic               full;

    assign accept = in_valid && in_ready && (state == LOAD);
    assign full   = (cnt == LW'(MAX_LEN));

    // Storage is never cleared; cnt alone says which entries are live.
    always_ff @(posedge clk) begin
        if (accept && !full) begin
            mem[AW'(cnt)] <= in_data;
        end
    end

    // Lane read ports; out-of-range lanes read entry 0 and are ignored.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lo_data[k] = mem[0];
            hi_data[k] = mem[0];
            if ((int'(lo) + k) < MAX_LEN) begin
                lo_data[k] = mem[AW'(int'(lo) + k)];
            end
            if ((int'(hi) - k) >= 0) begin
                hi_data[k] = mem[AW'(int'(hi) - k)];
            end
        end
    end

    pal_pair_cmp #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .LW    (LW)
    ) u_cmp (
        .lo         (lo),
        .hi         (hi),
        .lo_data    (lo_data),
        .hi_data    (hi_data),
        .mismatch   (mismatch),
        .last_group (last_group)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LOAD;
            cnt          <= '0;
            lo           <= '0;
            hi           <= '0;
            ovf          <= 1'b0;
            mism         <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_is_pal   <= 1'b0;
            out_len      <= '0;
            out_overflow <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        if (!full) begin
                            cnt <= cnt + 1'b1;
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (in_last) begin
                            in_ready <= 1'b0;
                            if (full) begin
                                // Overflow skips CHECK entirely.
                                state        <= RESULT;
                                out_valid    <= 1'b1;
                                out_is_pal   <= 1'b0;
                                out_len      <= cnt;
                                out_overflow <= 1'b1;
                            end else begin
                                state <= CHECK;
                                lo    <= '0;
                                hi    <= cnt;
                            end
                        end
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        mism         <= 1'b1;
                        state        <= RESULT;
                        out_valid    <= 1'b1;
                        out_is_pal   <= 1'b0;
                        out_len      <= cnt;
                        out_overflow <= ovf;
                    end else if (last_group) begin
                        state        <= RESULT;
                        out_valid    <= 1'b1;
                        out_is_pal   <= !mism && !ovf;
                        out_len      <= cnt;
                        out_overflow <= ovf;
                    end else begin
                        lo <= lo + LW'(LANES);
                        hi <= hi - LW'(LANES);
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state     <= LOAD;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        mism      <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pal_stream_checker.sv
// Directed bench for pal_stream_checker: LANES=1 and LANES=2 instances
// share one symbol stream; each result and its latency is checked.
module tb_pal_stream_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready1, out_valid1, out_is_pal1, out_overflow1;
    logic [4:0] out_len1;
    logic       in_ready2, out_valid2, out_is_pal2, out_overflow2;
    logic [4:0] out_len2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pal_stream_checker #(.WIDTH(4), .MAX_LEN(16), .LANES(1)) u1 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready1),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid1),
        .out_ready    (out_ready),
        .out_is_pal   (out_is_pal1),
        .out_len      (out_len1),
        .out_overflow (out_overflow1)
    );

    pal_stream_checker #(.WIDTH(4), .MAX_LEN(16), .LANES(2)) u2 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready2),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid2),
        .out_ready    (out_ready),
        .out_is_pal   (out_is_pal2),
        .out_len      (out_len2),
        .out_overflow (out_overflow2)
    );

    // Drive n symbols, first symbol in the most significant used nibble.
    // Returns after the edge that accepts the last beat (+#1).
    task automatic drive(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = v[4*(n-1-i) +: 4];
            in_last  = (i == n - 1);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_str(input string nm, input logic [127:0] v,
                           input int n, input logic e_pal, input int e_len,
                           input logic e_ovf, input int e_lat1,
                           input int e_lat2);
        int lat, lat1, lat2;
        logic p1, p2, o1, o2;
        int l1, l2;
        lat1 = -1;
        lat2 = -1;
        p1 = 0; p2 = 0; o1 = 0; o2 = 0; l1 = 0; l2 = 0;
        drive(v, n);
        lat = 1;
        while ((lat1 < 0 || lat2 < 0) && lat < 60) begin
            if (out_valid1 && lat1 < 0) begin
                lat1 = lat; p1 = out_is_pal1;
                l1 = int'(out_len1); o1 = out_overflow1;
            end
            if (out_valid2 && lat2 < 0) begin
                lat2 = lat; p2 = out_is_pal2;
                l2 = int'(out_len2); o2 = out_overflow2;
            end
            if (lat1 < 0 || lat2 < 0) begin
                @(posedge clk); #1;
                lat++;
            end
        end
        vectors += 8;
        if (lat1 !== e_lat1) begin
            miscompares++;
            $display("FAIL %s lanes1 latency got %0d want %0d", nm, lat1, e_lat1);
        end
        if (lat2 !== e_lat2) begin
            miscompares++;
            $display("FAIL %s lanes2 latency got %0d want %0d", nm, lat2, e_lat2);
        end
        if (p1 !== e_pal) begin
            miscompares++;
            $display("FAIL %s lanes1 is_pal got %0b want %0b", nm, p1, e_pal);
        end
        if (p2 !== e_pal) begin
            miscompares++;
            $display("FAIL %s lanes2 is_pal got %0b want %0b", nm, p2, e_pal);
        end
        if (l1 !== e_len) begin
            miscompares++;
            $display("FAIL %s lanes1 len got %0d want %0d", nm, l1, e_len);
        end
        if (l2 !== e_len) begin
            miscompares++;
            $display("FAIL %s lanes2 len got %0d want %0d", nm, l2, e_len);
        end
        if (o1 !== e_ovf) begin
            miscompares++;
            $display("FAIL %s lanes1 overflow got %0b want %0b", nm, o1, e_ovf);
        end
        if (o2 !== e_ovf) begin
            miscompares++;
            $display("FAIL %s lanes2 overflow got %0b want %0b", nm, o2, e_ovf);
        end
        // Both results were consumed on the following edge.
        @(posedge clk); #1;
        vectors += 2;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s lanes1 return rdy/vld got %0b/%0b want 1/0",
                     nm, in_ready1, out_valid1);
        end
        if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s lanes2 return rdy/vld got %0b/%0b want 1/0",
                     nm, in_ready2, out_valid2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        vectors += 2;
        if ({in_ready1, out_valid1, out_is_pal1, out_len1, out_overflow1}
            !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset lanes1 rdy/vld/pal/len/ovf got %0b/%0b/%0b/%0d/%0b want 1/0/0/0/0",
                     in_ready1, out_valid1, out_is_pal1, out_len1, out_overflow1);
        end
        if ({in_ready2, out_valid2, out_is_pal2, out_len2, out_overflow2}
            !== {1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset lanes2 rdy/vld/pal/len/ovf got %0b/%0b/%0b/%0d/%0b want 1/0/0/0/0",
                     in_ready2, out_valid2, out_is_pal2, out_len2, out_overflow2);
        end
    endtask

    task automatic test_match();
        run_str("pal_1221", 128'h1221, 4, 1'b1, 4, 1'b0, 3, 2);
        run_str("odd_37973", 128'h37973, 5, 1'b1, 5, 1'b0, 3, 2);
        run_str("single_7", 128'h7, 1, 1'b1, 1, 1'b0, 2, 2);
    endtask

    task automatic test_mismatch();
        run_str("late_1231", 128'h1231, 4, 1'b0, 4, 1'b0, 3, 2);
        run_str("early_5221", 128'h5221, 4, 1'b0, 4, 1'b0, 2, 2);
    endtask

    task automatic test_overflow();
        run_str("ovf_17xA", 128'hAAAAAAAAAAAAAAAAA, 17, 1'b0, 16, 1'b1, 1, 1);
        run_str("after_ovf_44", 128'h44, 2, 1'b1, 2, 1'b0, 2, 2);
    endtask

    task automatic test_hold();
        int waited;
        out_ready = 1'b0;
        drive(128'h1221, 4);
        waited = 0;
        while (!(out_valid1 && out_valid2) && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        vectors++;
        if (!(out_valid1 && out_valid2)) begin
            miscompares++;
            $display("FAIL hold result timeout vld1/vld2 got %0b/%0b want 1/1",
                     out_valid1, out_valid2);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 4'hF;
            in_last  = 1'b1;
            @(posedge clk); #1;
            vectors += 2;
            if ({out_valid1, out_is_pal1, out_len1, out_overflow1, in_ready1}
                !== {1'b1, 1'b1, 5'd4, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL hold%0d lanes1 vld/pal/len/ovf/rdy got %0b/%0b/%0d/%0b/%0b want 1/1/4/0/0",
                         c, out_valid1, out_is_pal1, out_len1, out_overflow1, in_ready1);
            end
            if ({out_valid2, out_is_pal2, out_len2, out_overflow2, in_ready2}
                !== {1'b1, 1'b1, 5'd4, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL hold%0d lanes2 vld/pal/len/ovf/rdy got %0b/%0b/%0d/%0b/%0b want 1/1/4/0/0",
                         c, out_valid2, out_is_pal2, out_len2, out_overflow2, in_ready2);
            end
        end
        // in_valid stays high across the handshake edge: must not be taken.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        vectors += 2;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL release lanes1 rdy/vld got %0b/%0b want 1/0",
                     in_ready1, out_valid1);
        end
        if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
            miscompares++;
            $display("FAIL release lanes2 rdy/vld got %0b/%0b want 1/0",
                     in_ready2, out_valid2);
        end
        run_str("after_hold_55", 128'h55, 2, 1'b1, 2, 1'b0, 2, 2);
    endtask

    task automatic test_reset_mid();
        drive(128'h1234321, 7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors += 2;
        if ({in_ready1, out_valid1, out_len1} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL midreset lanes1 rdy/vld/len got %0b/%0b/%0d want 1/0/0",
                     in_ready1, out_valid1, out_len1);
        end
        if ({in_ready2, out_valid2, out_len2} !== {1'b1, 1'b0, 5'd0}) begin
            miscompares++;
            $display("FAIL midreset lanes2 rdy/vld/len got %0b/%0b/%0d want 1/0/0",
                     in_ready2, out_valid2, out_len2);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid1 !== 1'b0 || out_valid2 !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_quiet%0d vld1/vld2 got %0b/%0b want 0/0",
                         c, out_valid1, out_valid2);
            end
        end
        run_str("after_reset_99", 128'h99, 2, 1'b1, 2, 1'b0, 2, 2);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_match();
        test_mismatch();
        test_overflow();
        test_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
